// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the bit-serial ALU controller.
//   state_t      : controller FSM states
//   MODE_*       : arithmetic / logic mode select
//   OP_*         : slice opcodes (arithmetic and logic sets overlap in encoding)
//   init_carry() : carry-in presented on bit 0 of an operation
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  // arithmetic mode opcodes
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_MOV   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b110;

  // logic mode opcodes
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_NOP = 3'b111;

  // The slice inverts b for SUB, so a carry-in of 1 completes the two's complement.
  function automatic logic init_carry(input logic mode, input logic [2:0] op);
    return (mode == MODE_ARITH) && (op == OP_SUB);
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Parallel-load, shift-right register with serial in at the MSB.
//   i_clk, i_reset   : clock, synchronous active-high reset (clears contents)
//   i_load/i_load_data : parallel load (has priority over shift)
//   i_shift/i_serial_in : shift right one place, i_serial_in enters at MSB
//   o_serial_out     : current LSB
//   o_data           : full register contents
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_shift,
  input  logic             i_serial_in,
  output logic             o_serial_out,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
    end else if (i_shift) begin
      r_data <= {i_serial_in, r_data[WIDTH-1:1]};
    end
  end

  assign o_serial_out = r_data[0];
  assign o_data       = r_data;

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer for an external one-bit ALU slice. Operands are sent
// LSB-first, one bit per clock, with the carry registered between bits; the
// WIDTH-bit result and carry/zero flags are assembled and held after done.
//
// Ports:
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_start / o_ready       : request, accepted only while o_ready=1
//   i_op_a, i_op_b          : operands (sampled on accepted start)
//   i_operation, i_mode     : opcode and mode (0 arith, 1 logic)
//   o_result, o_carry_flag, o_zero_flag : held from done until next start
//   o_done                  : one-cycle completion pulse
//   o_alu_a/b/cin/mode/op   : bit-level drive to the slice (0 outside RUN)
//   i_alu_out, i_alu_cout   : slice output and carry-out
//   o_overflow_flag         : only when OVERFLOW_FLAG_EN is defined
//
// Build option: OVERFLOW_FLAG_EN adds the signed-overflow flag.
//
// state | meaning
// IDLE  | ready, waiting for start
// RUN   | driving bit r_cnt of the operands to the slice
// DONE  | one-cycle done pulse, flags already registered
module serial_alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic [2:0]       i_operation,
  input  logic             i_mode,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry_flag,
  output logic             o_zero_flag,
  output logic             o_done,
`ifdef OVERFLOW_FLAG_EN
  output logic             o_overflow_flag,
`endif
  output logic             o_alu_a,
  output logic             o_alu_b,
  output logic             o_alu_cin,
  output logic             o_alu_mode,
  output logic [2:0]       o_alu_op,
  input  logic             i_alu_out,
  input  logic             i_alu_cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t r_state, w_state_next;

  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_prev_a;
  logic [2:0]       r_op;
  logic             r_mode;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_flag;
  logic             r_zero_flag;

  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic             w_is_shl;
  logic             w_a_lsb;
  logic             w_b_lsb;
  logic [WIDTH-1:0] w_res_sr;
  logic [WIDTH-1:0] w_res_final;
  logic [WIDTH-1:0] w_a_par_unused;
  logic [WIDTH-1:0] w_b_par_unused;
  logic             w_res_lsb_unused;

  assign w_accept = (r_state == IDLE) && i_start;
  assign w_run    = (r_state == RUN);
  assign w_last   = w_run && (r_cnt == CNT_LAST);
  assign w_is_shl = (r_mode == MODE_LOGIC) && (r_op == OP_SHL);

  serial_shift_reg #(.WIDTH(WIDTH)) u_sr_a (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_load       (w_accept),
    .i_load_data  (i_op_a),
    .i_shift      (w_run),
    .i_serial_in  (1'b0),
    .o_serial_out (w_a_lsb),
    .o_data       (w_a_par_unused)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_sr_b (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_load       (w_accept),
    .i_load_data  (i_op_b),
    .i_shift      (w_run),
    .i_serial_in  (1'b0),
    .o_serial_out (w_b_lsb),
    .o_data       (w_b_par_unused)
  );

  // Slice output enters at the MSB; after WIDTH shifts bit i sits at result[i].
  serial_shift_reg #(.WIDTH(WIDTH)) u_sr_res (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_load       (w_accept),
    .i_load_data  ({WIDTH{1'b0}}),
    .i_shift      (w_run),
    .i_serial_in  (i_alu_out),
    .o_serial_out (w_res_lsb_unused),
    .o_data       (w_res_sr)
  );

  // Value the result register will hold after the final shift.
  assign w_res_final = {i_alu_out, w_res_sr[WIDTH-1:1]};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_ready      = 1'b0;
    o_done       = 1'b0;
    o_alu_a      = 1'b0;
    o_alu_b      = 1'b0;
    o_alu_cin    = 1'b0;
    o_alu_mode   = 1'b0;
    o_alu_op     = 3'b000;
    case (r_state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_start) w_state_next = RUN;
      end
      RUN: begin
        // SHL: feed the previous A bit through the slice in pass-through mode.
        o_alu_a    = w_is_shl ? r_prev_a : w_a_lsb;
        o_alu_b    = w_b_lsb;
        o_alu_cin  = r_carry;
        o_alu_mode = r_mode;
        o_alu_op   = w_is_shl ? OP_NOP : r_op;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        o_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt        <= '0;
      r_carry      <= 1'b0;
      r_prev_a     <= 1'b0;
      r_op         <= 3'b000;
      r_mode       <= 1'b0;
      r_result     <= '0;
      r_carry_flag <= 1'b0;
      r_zero_flag  <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_carry  <= init_carry(i_mode, i_operation);
      r_prev_a <= 1'b0;
      r_op     <= i_operation;
      r_mode   <= i_mode;
    end else if (w_run) begin
      r_cnt    <= r_cnt + 1'b1;
      r_carry  <= i_alu_cout;
      r_prev_a <= w_a_lsb;
      if (w_last) begin
        r_result     <= w_res_final;
        r_carry_flag <= (r_mode == MODE_ARITH) ? i_alu_cout : 1'b0;
        r_zero_flag  <= (w_res_final == '0);
      end
    end
  end

`ifdef OVERFLOW_FLAG_EN
  logic r_overflow_flag;

  // On the last bit r_carry is the carry into the MSB.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_overflow_flag <= 1'b0;
    end else if (w_last) begin
      r_overflow_flag <= (r_mode == MODE_ARITH) ? (r_carry ^ i_alu_cout) : 1'b0;
    end
  end

  assign o_overflow_flag = r_overflow_flag;
`endif

  assign o_result     = r_result;
  assign o_carry_flag = r_carry_flag;
  assign o_zero_flag  = r_zero_flag;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
module tb_serial_alu_ctrl;
  import alu_ctrl_pkg::*;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             z;
    logic             v;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic [2:0]       operation = 3'b000;
  logic             mode = 1'b0;
  logic             ready;
  logic [WIDTH-1:0] result;
  logic             carry_flag;
  logic             zero_flag;
  logic             done;
  logic             ovf;
  logic             alu_a, alu_b, alu_cin, alu_mode;
  logic [2:0]       alu_op;
  logic             alu_out, alu_cout;

  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_start         (start),
    .o_ready         (ready),
    .i_op_a          (op_a),
    .i_op_b          (op_b),
    .i_operation     (operation),
    .i_mode          (mode),
    .o_result        (result),
    .o_carry_flag    (carry_flag),
    .o_zero_flag     (zero_flag),
    .o_done          (done),
`ifdef OVERFLOW_FLAG_EN
    .o_overflow_flag (ovf),
`endif
    .o_alu_a         (alu_a),
    .o_alu_b         (alu_b),
    .o_alu_cin       (alu_cin),
    .o_alu_mode      (alu_mode),
    .o_alu_op        (alu_op),
    .i_alu_out       (alu_out),
    .i_alu_cout      (alu_cout)
  );

`ifndef OVERFLOW_FLAG_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  // Behavioural one-bit ALU slice.
  always_comb begin
    alu_out  = alu_a;
    alu_cout = 1'b0;
    if (alu_mode == MODE_ARITH) begin
      case (alu_op)
        OP_ADD: {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {1'b0, alu_cin};
        OP_SUB: {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, ~alu_b} + {1'b0, alu_cin};
        default: alu_out = alu_a;
      endcase
    end else begin
      case (alu_op)
        OP_AND:  alu_out = alu_a & alu_b;
        OP_OR:   alu_out = alu_a | alu_b;
        OP_XOR:  alu_out = alu_a ^ alu_b;
        OP_NOT:  alu_out = ~alu_a;
        default: alu_out = alu_a;
      endcase
    end
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [2:0] op, input logic m);
    exp_t e;
    logic [WIDTH:0] s;
    s = {1'b0, a};
    e.c = 1'b0;
    e.v = 1'b0;
    if (m == MODE_ARITH) begin
      case (op)
        OP_ADD: begin
          s = {1'b0, a} + {1'b0, b};
          e.c = s[WIDTH];
          e.v = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
        end
        OP_SUB: begin
          s = {1'b0, a} + {1'b0, ~b} + 1'b1;
          e.c = s[WIDTH];
          e.v = (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
        end
        OP_MOV, OP_LOAD, OP_STORE: s = {1'b0, a};
        default: s = {1'b0, a};
      endcase
    end else begin
      case (op)
        OP_AND:  s = {1'b0, a & b};
        OP_OR:   s = {1'b0, a | b};
        OP_XOR:  s = {1'b0, a ^ b};
        OP_NOT:  s = {1'b0, ~a};
        OP_SHL:  s = {1'b0, a << 1};
        OP_NOP:  s = {1'b0, a};
        default: s = {1'b0, a};
      endcase
    end
    e.res = s[WIDTH-1:0];
    e.z   = (e.res == '0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation; with inject=1 a second start is pulsed during RUN.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] op, input logic m, input string name,
                        input bit inject);
    exp_t e;
    int   cyc;
    int   dc0;
    bit   ready_bad;
    sb.push_back(model(a, b, op, m));
    dc0 = done_cnt;
    op_a = a; op_b = b; operation = op; mode = m; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    ready_bad = 1'b0;
    while (done !== 1'b1 && cyc < 4 * WIDTH) begin
      if (ready !== 1'b0) ready_bad = 1'b1;
      if (inject && cyc == 2) begin
        op_a = ~a; op_b = 8'h3C; operation = OP_XOR; mode = MODE_LOGIC; start = 1'b1;
      end
      if (inject && cyc == 4) start = 1'b0;
      tick();
      cyc++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_errors++;
      $display("FAIL %s done_timeout: no done within %0d cycles", name, 4 * WIDTH);
    end
    n_checks++;
    if (cyc !== WIDTH) begin
      n_errors++;
      $display("FAIL %s latency: got %0d edges after start, want %0d", name, cyc, WIDTH);
    end
    n_checks++;
    if (ready_bad || ready !== 1'b0) begin
      n_errors++;
      $display("FAIL %s ready_busy: ready high while busy (done-cycle ready=%b), want 0", name, ready);
    end
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s scoreboard: empty, want 1 entry", name);
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (result !== e.res) begin
        n_errors++;
        $display("FAIL %s result: got %h want %h", name, result, e.res);
      end
      n_checks++;
      if (carry_flag !== e.c) begin
        n_errors++;
        $display("FAIL %s carry_flag: got %b want %b", name, carry_flag, e.c);
      end
      n_checks++;
      if (zero_flag !== e.z) begin
        n_errors++;
        $display("FAIL %s zero_flag: got %b want %b", name, zero_flag, e.z);
      end
`ifdef OVERFLOW_FLAG_EN
      n_checks++;
      if (ovf !== e.v) begin
        n_errors++;
        $display("FAIL %s overflow_flag: got %b want %b", name, ovf, e.v);
      end
`endif
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s after_done: got done=%b ready=%b want done=0 ready=1", name, done, ready);
    end
    if (inject) repeat (WIDTH + 2) tick();
    n_checks++;
    if (done_cnt - dc0 !== 1) begin
      n_errors++;
      $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt - dc0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got ready=%b done=%b want ready=1 done=0", ready, done);
    end
    n_checks++;
    if (result !== '0 || carry_flag !== 1'b0 || zero_flag !== 1'b0 || ovf !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got result=%h c=%b z=%b v=%b want all 0",
               result, carry_flag, zero_flag, ovf);
    end
    n_checks++;
    if ({alu_a, alu_b, alu_cin, alu_mode, alu_op} !== 7'd0) begin
      n_errors++;
      $display("FAIL reset_alu_drive: got %b want 0000000",
               {alu_a, alu_b, alu_cin, alu_mode, alu_op});
    end
  endtask

  task automatic test_arith();
    run_op(8'hFF, 8'h01, OP_ADD, MODE_ARITH, "add_ff_01", 1'b0);
    run_op(8'h05, 8'h07, OP_SUB, MODE_ARITH, "sub_05_07", 1'b0);
    run_op(8'h07, 8'h07, OP_SUB, MODE_ARITH, "sub_07_07", 1'b0);
    run_op(8'h7F, 8'h01, OP_ADD, MODE_ARITH, "add_7f_01", 1'b0);
    run_op(8'h80, 8'h01, OP_SUB, MODE_ARITH, "sub_80_01", 1'b0);
  endtask

  task automatic test_logic();
    run_op(8'hA5, 8'hFF, OP_XOR, MODE_LOGIC, "xor_a5_ff", 1'b0);
    run_op(8'h81, 8'h00, OP_SHL, MODE_LOGIC, "shl_81", 1'b0);
    run_op(8'h0F, 8'h00, OP_NOT, MODE_LOGIC, "not_0f", 1'b0);
    run_op(8'hC3, 8'h5A, OP_AND, MODE_LOGIC, "and_c3_5a", 1'b0);
    run_op(8'h30, 8'h05, OP_OR,  MODE_LOGIC, "or_30_05", 1'b0);
  endtask

  task automatic test_ignore_start();
    run_op(8'h12, 8'h34, OP_ADD, MODE_ARITH, "ignore_start", 1'b1);
  endtask

  task automatic test_reset_mid_run();
    int dc0;
    dc0 = done_cnt;
    op_a = 8'h55; op_b = 8'h11; operation = OP_ADD; mode = MODE_ARITH; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL midrun_reset_ctrl: got ready=%b done=%b want ready=1 done=0", ready, done);
    end
    n_checks++;
    if (result !== '0 || carry_flag !== 1'b0 || zero_flag !== 1'b0 || ovf !== 1'b0) begin
      n_errors++;
      $display("FAIL midrun_reset_outputs: got result=%h c=%b z=%b v=%b want all 0",
               result, carry_flag, zero_flag, ovf);
    end
    repeat (WIDTH + 2) tick();
    n_checks++;
    if (done_cnt !== dc0) begin
      n_errors++;
      $display("FAIL midrun_reset_no_done: got %0d pulses want 0", done_cnt - dc0);
    end
    run_op(8'h03, 8'h04, OP_ADD, MODE_ARITH, "add_after_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_ignore_start();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
